// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and width helpers for uart_rx_cfg.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic int cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction
  function automatic int idx_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction
  localparam int CNT_W = cnt_w(868);
  localparam int IDX_W = idx_w(8);
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the idle-high serial line, resets to 1.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ff_q <= 2'b11;
    else        ff_q <= {ff_q[0], d_i};
  end
  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with framing/parity error strobes.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_data,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid_data,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 rx_busy
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int IW = idx_w(DATA_BITS);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SLAST = IW'(STOP_BITS - 1);

  logic rx_s;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d;
  logic valid_q, valid_d, fstb_q, fstb_d, pstb_q, pstb_d;
  logic tick;

  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(i_data), .q_o(rx_s));

  assign tick = cnt_q == FULL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      fstb_q  <= 1'b0;
      pstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
      fstb_q  <= fstb_d;
      pstb_q  <= pstb_d;
    end
  end

  // brk_q remembers a line stuck low after a frame error so a held break
  // only bounces IDLE<->START until the line goes high again.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    brk_d   = brk_q & ~rx_s;
    valid_d = 1'b0;
    fstb_d  = 1'b0;
    pstb_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        state_d = (rx_s || brk_q) ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d   = '0;
        perr_d  = ^{sh_q, rx_s} ^ i_parity_odd;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        cnt_d  = '0;
        ferr_d = ferr_q | ~rx_s;
        idx_d  = idx_q + 1'b1;
        if (idx_q == SLAST) begin
          idx_d   = '0;
          state_d = IDLE;
          data_d  = sh_q;
          fstb_d  = ferr_d;
          pstb_d  = ~ferr_d & perr_q;
          valid_d = ~ferr_d & ~perr_q;
          brk_d   = ~rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data       = data_q;
  assign o_valid_data = valid_q;
  assign o_frame_err  = fstb_q;
  assign rx_busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = pstb_q;
`else
  logic unused_par;
  assign unused_par   = i_parity_odd ^ pstb_q;
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: frame-level model and directed frames for two receiver configurations.
module tb_uart_rx_cfg;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       v, f, p;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, rx8 = 1'b1, rx7 = 1'b1, par_odd = 1'b0;
  logic [7:0] o_data8;
  logic [6:0] o_data7;
  logic v8, f8, p8, busy8, v7, f7, p7, busy7;
  int cyc = 0, errors = 0, checks = 0, n = 0;
  bit run = 1'b0;
  exp_t q8[$], q7[$];
  logic [8:0] last8 = '0, last7 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_data(rx8), .i_parity_odd(par_odd),
    .o_data(o_data8), .o_valid_data(v8), .o_frame_err(f8),
    .o_parity_err(p8), .rx_busy(busy8));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst_n(rst_n), .i_data(rx7), .i_parity_odd(par_odd),
    .o_data(o_data7), .o_valid_data(v7), .o_frame_err(f7),
    .o_parity_err(p7), .rx_busy(busy7));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (run) begin : cmp8
    exp_t e;
    bit hit;
    hit = q8.size() > 0 && q8[0].cyc == cyc;
    e = hit ? q8[0] : '{cyc: 0, data: last8, v: 1'b0, f: 1'b0, p: 1'b0};
    chk("d8_valid", 32'(v8), 32'(e.v));
    chk("d8_frame_err", 32'(f8), 32'(e.f));
    chk("d8_parity_err", 32'(p8), 32'(e.p));
    chk("d8_data", 32'(o_data8), 32'(e.data));
    if (hit) begin
      last8 = e.data;
      void'(q8.pop_front());
    end
  end

  always @(negedge clk) if (run) begin : cmp7
    exp_t e;
    bit hit;
    hit = q7.size() > 0 && q7[0].cyc == cyc;
    e = hit ? q7[0] : '{cyc: 0, data: last7, v: 1'b0, f: 1'b0, p: 1'b0};
    chk("d7_valid", 32'(v7), 32'(e.v));
    chk("d7_frame_err", 32'(f7), 32'(e.f));
    chk("d7_parity_err", 32'(p7), 32'(e.p));
    chk("d7_data", 32'(o_data7), 32'(e.data));
    if (hit) begin
      last7 = e.data;
      void'(q7.pop_front());
    end
  end

  task automatic put(input bit w7, input logic b);
    if (w7) rx7 = b;
    else    rx8 = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the line drop is first sampled one edge later.
  task automatic send(input bit w7, input logic [8:0] word, input bit flip, input logic [1:0] stops);
    int db, sb;
    logic [8:0] w;
    logic pb;
    exp_t e;
    db = w7 ? 7 : 8;
    sb = w7 ? 2 : 1;
    w  = word & ((9'd1 << db) - 9'd1);
    pb = (^w) ^ par_odd ^ flip;
    e.cyc  = cyc + 3 + CPB / 2 + CPB * (db + PAR + sb);
    e.data = w;
    e.f    = 1'b0;
    for (int i = 0; i < sb; i++) if (!stops[i]) e.f = 1'b1;
    e.p = PAR != 0 && ((^w) ^ pb) != par_odd && !e.f;
    e.v = !e.f && !e.p;
    if (w7) q7.push_back(e);
    else    q8.push_back(e);
    put(w7, 1'b0);
    for (int i = 0; i < db; i++) put(w7, w[i]);
    if (PAR != 0) put(w7, pb);
    for (int i = 0; i < sb; i++) put(w7, stops[i]);
  endtask

  task automatic idle(input int k);
    rx8 = 1'b1;
    rx7 = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q8.delete();
    q7.delete();
    last8 = '0;
    last7 = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data8", 32'(o_data8), 0);
    chk("rst_data7", 32'(o_data7), 0);
    chk("rst_strobes", 32'({v8, f8, p8, v7, f7, p7}), 0);
    chk("rst_busy", 32'({busy8, busy7}), 0);
    rst_n = 1'b1;
    run = 1'b1;
    idle(20);
    // 0xA5 8N1: strobe 9.5 bit periods + 2 cycles after the first low sample
    n = cyc;
    fork
      send(1'b0, 9'h0A5, 1'b0, 2'b11);
      begin
        wait_to(n + 100);
        chk("t1_busy_mid", 32'(busy8), 1);
        wait_to(n + (PAR != 0 ? 171 : 155));
        chk("t1_valid_at", 32'(v8), 1);
        chk("t1_data_at", 32'(o_data8), 32'h0A5);
      end
    join
    idle(30);
    chk("t1_busy_after", 32'(busy8), 0);
    // short start glitch
    n = cyc;
    rx8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx8 = 1'b1;
    wait_to(n + 10);
    chk("t2_busy_hi", 32'(busy8), 1);
    wait_to(n + 11);
    chk("t2_busy_lo", 32'(busy8), 0);
    @(posedge clk);
    #1;
    idle(30);
    send(1'b0, 9'h03C, 1'b0, 2'b10);
    idle(30);
    chk("t3_data", 32'(o_data8), 32'h3C);
    // break: whole frame low, line held low for many bit times
    send(1'b0, 9'h000, 1'b0, 2'b10);
    repeat (300) @(posedge clk);
    #1;
    idle(40);
    send(1'b0, 9'h0C3, 1'b0, 2'b11);
    idle(30);
    chk("brk_recover", 32'(o_data8), 32'hC3);
`ifdef UART_RX_PARITY_EN
    par_odd = 1'b0;
    send(1'b0, 9'h007, 1'b0, 2'b11);
    idle(30);
    send(1'b0, 9'h007, 1'b1, 2'b11);
    idle(30);
    par_odd = 1'b1;
    send(1'b0, 9'h007, 1'b0, 2'b11);
    idle(30);
    par_odd = 1'b0;
`endif
    send(1'b1, 9'h055, 1'b0, 2'b11);
    send(1'b1, 9'h02A, 1'b0, 2'b11);
    idle(30);
    chk("t5_data7", 32'(o_data7), 32'h2A);
    send(1'b1, 9'h013, 1'b0, 2'b01);
    idle(30);
    chk("t5_data7_ferr", 32'(o_data7), 32'h13);
    // reset during data bit 4 of a frame
    rx8 = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx8 = i[0];
      repeat (CPB) @(posedge clk);
    end
    #1 rx8 = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    chk("t6_busy_pre", 32'(busy8), 1);
    do_reset();
    chk("t6_data_post", 32'(o_data8), 0);
    chk("t6_busy_post", 32'(busy8), 0);
    idle(40);
    send(1'b0, 9'h0FF, 1'b0, 2'b11);
    idle(30);
    chk("t6_data_ff", 32'(o_data8), 32'hFF);
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q7_drained", 32'(q7.size()), 0);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
